// File: rtl/apb_demux_n.sv
// Registered APB4 1-to-NUM_SLV demultiplexer: base/mask decode, DECERR for unmapped
// addresses, per-transfer slave timeout and a saturating error counter.
module apb_demux_n #(
  parameter int                          NUM_SLV  = 4,
  parameter int                          ADDR_W   = 32,
  parameter int                          DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = {32'h1000_2000, 32'h1000_1000,
                                                     32'h1000_0000, 32'h3000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = {32'hFFFF_F000, 32'hFFFF_F000,
                                                     32'hFFFF_F000, 32'hF000_0000},
  parameter int                          TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]           ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [ADDR_W-1:0]         s_paddr,
  input  logic                      s_psel,
  input  logic                      s_penable,
  input  logic                      s_pwrite,
  input  logic [DATA_W-1:0]         s_pwdata,
  input  logic [DATA_W/8-1:0]       s_pwstrb,
  output logic                      s_pready,
  output logic [DATA_W-1:0]         s_prdata,
  output logic                      s_pslverr,
  output logic [ADDR_W-1:0]         m_paddr,
  output logic [NUM_SLV-1:0]        m_psel,
  output logic                      m_penable,
  output logic                      m_pwrite,
  output logic [DATA_W-1:0]         m_pwdata,
  output logic [DATA_W/8-1:0]       m_pwstrb,
  input  logic [NUM_SLV-1:0]        m_pready,
  input  logic [NUM_SLV*DATA_W-1:0] m_prdata,
  input  logic [NUM_SLV-1:0]        m_pslverr,
  output logic [7:0]                err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TO_W   = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pwstrb_q, pwstrb_d;
  logic [NUM_SLV-1:0]  mPsel_q, mPsel_d;
  logic                mPenable_q, mPenable_d;
  logic                sPready_q, sPready_d;
  logic [DATA_W-1:0]   sPrdata_q, sPrdata_d;
  logic                sPslverr_q, sPslverr_d;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic [7:0]          errCnt_q, errCnt_d;

  logic                hit;
  logic [IDX_W-1:0]    hitIdx;
  logic [NUM_SLV-1:0]  hitSel;
  logic                selReady;
  logic                selErr;
  logic [DATA_W-1:0]   selData;
  logic [7:0]          errCntInc;

  // Scanning downward lets the lowest matching index overwrite any higher match.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    hitSel = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((s_paddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit       = 1'b1;
        hitIdx    = IDX_W'(i);
        hitSel    = '0;
        hitSel[i] = 1'b1;
      end
    end
  end

  assign selReady  = m_pready[idx_q];
  assign selErr    = m_pslverr[idx_q];
  assign selData   = m_prdata[idx_q*DATA_W +: DATA_W];
  assign errCntInc = (errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pwstrb_d   = pwstrb_q;
    mPsel_d    = mPsel_q;
    mPenable_d = mPenable_q;
    sPready_d  = 1'b0;
    sPrdata_d  = '0;
    sPslverr_d = 1'b0;
    toCnt_d    = toCnt_q;
    errCnt_d   = errCnt_q;

    case (state_q)
      IDLE: begin
        if (s_psel && !s_penable) begin
          idx_d    = hitIdx;
          paddr_d  = s_paddr;
          pwrite_d = s_pwrite;
          pwdata_d = s_pwdata;
          pwstrb_d = s_pwrite ? s_pwstrb : '0;
          if (hit) begin
            state_d    = SETUP;
            mPsel_d    = hitSel;
            mPenable_d = 1'b0;
          end else begin
            state_d    = ERR;
            sPready_d  = 1'b1;
            sPslverr_d = 1'b1;
            sPrdata_d  = ERR_DATA;
            errCnt_d   = errCntInc;
          end
        end
      end

      SETUP: begin
        state_d    = ACCESS;
        mPenable_d = 1'b1;
        toCnt_d    = '0;
      end

      // A ready slave always wins over the timeout in the same cycle.
      ACCESS: begin
        if (selReady) begin
          state_d    = DONE;
          mPsel_d    = '0;
          mPenable_d = 1'b0;
          sPready_d  = 1'b1;
          sPrdata_d  = selData;
          sPslverr_d = selErr;
          toCnt_d    = '0;
        end else if (toCnt_q == TO_LAST) begin
          state_d    = DONE;
          mPsel_d    = '0;
          mPenable_d = 1'b0;
          sPready_d  = 1'b1;
          sPrdata_d  = ERR_DATA;
          sPslverr_d = 1'b1;
          toCnt_d    = '0;
          errCnt_d   = errCntInc;
        end else begin
          toCnt_d = toCnt_q + 16'd1;
        end
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pwstrb_q   <= '0;
      mPsel_q    <= '0;
      mPenable_q <= 1'b0;
      sPready_q  <= 1'b0;
      sPrdata_q  <= '0;
      sPslverr_q <= 1'b0;
      toCnt_q    <= '0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pwstrb_q   <= pwstrb_d;
      mPsel_q    <= mPsel_d;
      mPenable_q <= mPenable_d;
      sPready_q  <= sPready_d;
      sPrdata_q  <= sPrdata_d;
      sPslverr_q <= sPslverr_d;
      toCnt_q    <= toCnt_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign s_pready  = sPready_q;
  assign s_prdata  = sPrdata_q;
  assign s_pslverr = sPslverr_q;
  assign m_paddr   = paddr_q;
  assign m_psel    = mPsel_q;
  assign m_penable = mPenable_q;
  assign m_pwrite  = pwrite_q;
  assign m_pwdata  = pwdata_q;
  assign m_pwstrb  = pwstrb_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_apb_demux_n.sv
// Self-checking bench for apb_demux_n: transaction-level timing model checked every cycle,
// plus directed transfers with hand-computed literal results.
`timescale 1ns/1ps
module tb_apb_demux_n;

  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [31:0] BASES [4] = '{32'h3000_0000, 32'h1000_0000, 32'h1000_1000, 32'h1000_2000};
  localparam logic [31:0] MASKS [4] = '{32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic         pclk = 1'b0;
  logic         preset = 1'b1;
  logic [31:0]  s_paddr = '0;
  logic         s_psel = 1'b0;
  logic         s_penable = 1'b0;
  logic         s_pwrite = 1'b0;
  logic [31:0]  s_pwdata = '0;
  logic [3:0]   s_pwstrb = '0;
  logic         s_pready;
  logic [31:0]  s_prdata;
  logic         s_pslverr;
  logic [31:0]  m_paddr;
  logic [3:0]   m_psel;
  logic         m_penable;
  logic         m_pwrite;
  logic [31:0]  m_pwdata;
  logic [3:0]   m_pwstrb;
  logic [3:0]   m_pready;
  logic [127:0] m_prdata;
  logic [3:0]   m_pslverr;
  logic [7:0]   err_cnt;

  apb_demux_n #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave models: slave i answers after waitCfg[i] wait states with fixed data/error.
  int          waitCfg [4];
  logic [31:0] rdCfg   [4];
  logic        errCfg  [4];
  int          accCnt  [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m_pready[i]            = m_psel[i] & m_penable & (accCnt[i] >= waitCfg[i]);
      m_pslverr[i]           = errCfg[i];
      m_prdata[i*32 +: 32]   = rdCfg[i];
    end
  end

  always @(posedge pclk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_psel[i] && m_penable) accCnt[i] <= accCnt[i] + 1;
      else                        accCnt[i] <= 0;
    end
  end

  // Transaction-level model: each accepted request fixes its select window and response cycle.
  int          cyc = 0;
  bit          started = 0;
  bit          active = 0;
  bit          mapped;
  int          baseCyc, respCyc, idx, expErrCnt = 0;
  logic [3:0]  expSel, expStrb;
  logic [31:0] expAddr, expWdata, expData;
  logic        expWrite, expErr, countsErr;
  bit          inSel, inEn, inResp;

  always begin
    @(posedge pclk);
    if (preset) begin
      active    = 0;
      expErrCnt = 0;
      started   = 1;
    end else if ((!active || cyc > respCyc) && s_psel && !s_penable) begin
      idx = -1;
      for (int i = 0; i < 4; i++)
        if (idx < 0 && (s_paddr & MASKS[i]) == BASES[i]) idx = i;
      active   = 1;
      baseCyc  = cyc;
      expAddr  = s_paddr;
      expWrite = s_pwrite;
      expWdata = s_pwdata;
      expStrb  = s_pwrite ? s_pwstrb : 4'h0;
      if (idx < 0) begin
        mapped = 0; expSel = 4'h0; respCyc = cyc + 1;
        expData = ERRD; expErr = 1'b1; countsErr = 1'b1;
      end else begin
        mapped = 1; expSel = 4'(1 << idx);
        if (waitCfg[idx] >= TO) begin
          respCyc = cyc + 2 + TO; expData = ERRD; expErr = 1'b1; countsErr = 1'b1;
        end else begin
          respCyc = cyc + 3 + waitCfg[idx]; expData = rdCfg[idx]; expErr = errCfg[idx]; countsErr = 1'b0;
        end
      end
    end
    cyc++;
    @(negedge pclk);
    if (started) begin
      inSel  = active && mapped && cyc >= baseCyc + 1 && cyc <= respCyc - 1;
      inEn   = active && mapped && cyc >= baseCyc + 2 && cyc <= respCyc - 1;
      inResp = active && cyc == respCyc;
      if (inResp && countsErr && expErrCnt < 255) expErrCnt++;
      checkOutput("m_psel",    m_psel,    inSel ? expSel : 4'h0);
      checkOutput("m_penable", m_penable, inEn);
      checkOutput("s_pready",  s_pready,  inResp);
      checkOutput("s_prdata",  s_prdata,  inResp ? expData : 32'h0);
      checkOutput("s_pslverr", s_pslverr, inResp ? expErr : 1'b0);
      checkOutput("err_cnt",   err_cnt,   expErrCnt);
      if (inSel) begin
        checkOutput("m_paddr",  m_paddr,  expAddr);
        checkOutput("m_pwrite", m_pwrite, expWrite);
        checkOutput("m_pwdata", m_pwdata, expWdata);
        checkOutput("m_pwstrb", m_pwstrb, expStrb);
      end
    end
  end

  // Upstream APB master: setup, enable, wait for ready; lat = cycles from T to s_pready.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input logic [3:0] strb, output logic [31:0] rdata,
                               output logic err, output int lat);
    bit got = 0;
    lat = 0; rdata = '0; err = 1'b0;
    s_paddr = addr; s_pwrite = wr; s_pwdata = wdata; s_pwstrb = strb;
    s_psel = 1'b1; s_penable = 1'b0;
    @(posedge pclk); #1;
    s_penable = 1'b1;
    while (!got && lat < 100) begin
      @(negedge pclk);
      lat++;
      if (s_pready) begin
        got = 1; rdata = s_prdata; err = s_pslverr;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL resp_wait: actual=no s_pready required=s_pready within 100 cycles");
    end
    @(posedge pclk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    for (int i = 0; i < 4; i++) begin
      waitCfg[i] = 0; rdCfg[i] = 32'hC0DE_0000 + 32'(i); errCfg[i] = 1'b0; accCnt[i] = 0;
    end
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    checkOutput("reset_m_paddr",  m_paddr,  32'h0);
    checkOutput("reset_m_pwdata", m_pwdata, 32'h0);
    checkOutput("reset_m_pwstrb", m_pwstrb, 4'h0);
    checkOutput("reset_m_pwrite", m_pwrite, 1'b0);
    checkOutput("reset_err_cnt",  err_cnt,  8'h00);
    @(posedge pclk); #1;

    $display("[TB] zero-wait read of slave 2");
    rdCfg[2] = 32'h0000_00A5;
    applyStimulus(32'h1000_1004, 1'b0, 32'h1111_1111, 4'hF, rd, er, lt);
    checkOutput("t1_rdata", rd, 32'h0000_00A5);
    checkOutput("t1_err",   er, 1'b0);
    checkOutput("t1_lat",   lt, 3);

    $display("[TB] write to slave 0 with three wait states");
    waitCfg[0] = 3; rdCfg[0] = 32'h0000_0077;
    applyStimulus(32'h3000_0010, 1'b1, 32'h1234_5678, 4'hF, rd, er, lt);
    checkOutput("t2_rdata", rd, 32'h0000_0077);
    checkOutput("t2_err",   er, 1'b0);
    checkOutput("t2_lat",   lt, 6);

    $display("[TB] unmapped read");
    applyStimulus(32'h2000_0000, 1'b0, 32'h0, 4'h0, rd, er, lt);
    checkOutput("t3_rdata",   rd, ERRD);
    checkOutput("t3_err",     er, 1'b1);
    checkOutput("t3_lat",     lt, 1);
    checkOutput("t3_err_cnt", err_cnt, 8'd1);

    $display("[TB] slave 1 never ready");
    waitCfg[1] = 1000;
    applyStimulus(32'h1000_0040, 1'b0, 32'h0, 4'hF, rd, er, lt);
    checkOutput("t4_rdata",   rd, ERRD);
    checkOutput("t4_err",     er, 1'b1);
    checkOutput("t4_lat",     lt, 10);
    checkOutput("t4_err_cnt", err_cnt, 8'd2);

    $display("[TB] write to slave 2 returning a slave error");
    errCfg[2] = 1'b1; rdCfg[2] = 32'h0000_0B0B;
    applyStimulus(32'h1000_1FFC, 1'b1, 32'hCAFE_F00D, 4'h3, rd, er, lt);
    checkOutput("t4b_rdata",   rd, 32'h0000_0B0B);
    checkOutput("t4b_err",     er, 1'b1);
    checkOutput("t4b_lat",     lt, 3);
    checkOutput("t4b_err_cnt", err_cnt, 8'd2);
    errCfg[2] = 1'b0;

    $display("[TB] 300 unmapped reads");
    for (int n = 0; n < 300; n++)
      applyStimulus(32'h2000_0000 + 32'(n * 4), 1'b0, 32'h0, 4'h0, rd, er, lt);
    checkOutput("t5_err_cnt", err_cnt, 8'hFF);

    $display("[TB] reset during access of slave 3");
    waitCfg[3] = 1000;
    s_paddr = 32'h1000_2008; s_pwrite = 1'b0; s_pwstrb = 4'hF; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge pclk); #1;
    s_penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    @(negedge pclk);
    checkOutput("t6_m_psel",    m_psel,    4'h0);
    checkOutput("t6_m_penable", m_penable, 1'b0);
    checkOutput("t6_s_pready",  s_pready,  1'b0);
    checkOutput("t6_err_cnt",   err_cnt,   8'h00);
    @(posedge pclk); #1;
    waitCfg[3] = 0; rdCfg[3] = 32'h5A5A_0003;
    applyStimulus(32'h1000_2008, 1'b0, 32'h0, 4'hF, rd, er, lt);
    checkOutput("t6_rdata", rd, 32'h5A5A_0003);
    checkOutput("t6_err",   er, 1'b0);
    checkOutput("t6_lat",   lt, 3);

    repeat (2) @(posedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
